// File: rtl/time_set_ctrl.sv
// Time-setting controller for the hh:mm:ss clock.
// Debounced buttons drive a BCD edit FSM with per-field blink.

module btn_deb #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int DW = $clog2(DEB_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_q;
  logic [DW-1:0] cnt;

  // Synchronise, accept a level after a stable run, pulse on rise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_q <= level;
      press   <= level & ~level_q;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == DW'(DEB_CYCLES)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

module time_set_ctrl #(
  parameter int DEB_CYCLES = 1000000,
  parameter int BLINK_HALF = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [1:0] cur_hour_h,
  input  logic [3:0] cur_hour_l,
  input  logic [2:0] cur_minute_h,
  input  logic [3:0] cur_minute_l,
  input  logic [2:0] cur_second_h,
  input  logic [3:0] cur_second_l,
  output logic       stop,
  output logic       load,
  output logic [1:0] set_hour_h,
  output logic [3:0] set_hour_l,
  output logic [2:0] set_minute_h,
  output logic [3:0] set_minute_l,
  output logic [2:0] set_second_h,
  output logic [3:0] set_second_l,
  output logic [5:0] blink,
  output logic [1:0] mode
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } state_t;

  localparam int BW = $clog2(BLINK_HALF + 1);

  state_t        state;
  logic          mode_p;
  logic          inc_p;
  logic          phase;
  logic [BW-1:0] bcnt;

  btn_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_mode),
    .press (mode_p)
  );

  btn_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_inc),
    .press (inc_p)
  );

  assign mode = state;

  function automatic logic [5:0] inc_hour(
    input logic [1:0] h,
    input logic [3:0] l
  );
    if (h == 2'd2 && l == 4'd3) return 6'd0;
    else if (l == 4'd9)         return {h + 2'd1, 4'd0};
    else                        return {h, l + 4'd1};
  endfunction

  function automatic logic [6:0] inc_ms(
    input logic [2:0] h,
    input logic [3:0] l
  );
    if (l == 4'd9) return (h == 3'd5) ? 7'd0 : {h + 3'd1, 4'd0};
    else           return {h, l + 4'd1};
  endfunction

  function automatic logic [5:0] field_mask(input state_t s);
    unique case (s)
      SET_H:   return 6'b110000;
      SET_M:   return 6'b001100;
      SET_S:   return 6'b000011;
      default: return 6'b000000;
    endcase
  endfunction

  // Mode FSM, BCD field edits, load strobe and blink timer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= RUN;
      stop         <= 1'b0;
      load         <= 1'b0;
      blink        <= 6'd0;
      phase        <= 1'b0;
      bcnt         <= '0;
      set_hour_h   <= '0;
      set_hour_l   <= '0;
      set_minute_h <= '0;
      set_minute_l <= '0;
      set_second_h <= '0;
      set_second_l <= '0;
    end else begin
      load <= 1'b0;

      if (state == RUN || mode_p) begin
        phase <= 1'b0;
        bcnt  <= '0;
        blink <= 6'd0;
      end else if (bcnt == BW'(BLINK_HALF - 1)) begin
        bcnt  <= '0;
        phase <= ~phase;
        blink <= phase ? 6'd0 : field_mask(state);
      end else begin
        bcnt <= bcnt + 1'b1;
      end

      unique case (state)
        RUN: begin
          stop <= 1'b0;
          if (mode_p) begin
            state        <= SET_H;
            stop         <= 1'b1;
            set_hour_h   <= cur_hour_h;
            set_hour_l   <= cur_hour_l;
            set_minute_h <= cur_minute_h;
            set_minute_l <= cur_minute_l;
            set_second_h <= cur_second_h;
            set_second_l <= cur_second_l;
          end
        end
        SET_H: begin
          if (mode_p)
            state <= SET_M;
          else if (inc_p)
            {set_hour_h, set_hour_l} <=
              inc_hour(set_hour_h, set_hour_l);
        end
        SET_M: begin
          if (mode_p)
            state <= SET_S;
          else if (inc_p)
            {set_minute_h, set_minute_l} <=
              inc_ms(set_minute_h, set_minute_l);
        end
        SET_S: begin
          if (mode_p) begin
            state <= RUN;
            load  <= 1'b1;
          end else if (inc_p) begin
            {set_second_h, set_second_l} <=
              inc_ms(set_second_h, set_second_l);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: button-level stimulus against
// an arithmetic model of the edit sequence and blink timing.

module tb_time_set_ctrl;

  localparam int DEB  = 4;
  localparam int BH   = 8;
  localparam int HOLD = 12;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode;
  logic       btn_inc;
  logic [1:0] cur_hour_h;
  logic [3:0] cur_hour_l;
  logic [2:0] cur_minute_h;
  logic [3:0] cur_minute_l;
  logic [2:0] cur_second_h;
  logic [3:0] cur_second_l;
  logic       stop;
  logic       load;
  logic [1:0] set_hour_h;
  logic [3:0] set_hour_l;
  logic [2:0] set_minute_h;
  logic [3:0] set_minute_l;
  logic [2:0] set_second_h;
  logic [3:0] set_second_l;
  logic [5:0] blink;
  logic [1:0] mode;

  logic [19:0] set_all;
  assign set_all = {set_hour_h, set_hour_l, set_minute_h,
                    set_minute_l, set_second_h, set_second_l};

  time_set_ctrl #(.DEB_CYCLES(DEB), .BLINK_HALF(BH)) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_mode     (btn_mode),
    .btn_inc      (btn_inc),
    .cur_hour_h   (cur_hour_h),
    .cur_hour_l   (cur_hour_l),
    .cur_minute_h (cur_minute_h),
    .cur_minute_l (cur_minute_l),
    .cur_second_h (cur_second_h),
    .cur_second_l (cur_second_l),
    .stop         (stop),
    .load         (load),
    .set_hour_h   (set_hour_h),
    .set_hour_l   (set_hour_l),
    .set_minute_h (set_minute_h),
    .set_minute_l (set_minute_l),
    .set_second_h (set_second_h),
    .set_second_l (set_second_l),
    .blink        (blink),
    .mode         (mode)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int load_cnt = 0;
  bit prev_load = 1'b0;

  int m_mode = 0, m_h = 0, m_m = 0, m_s = 0;
  int c_h = 0, c_m = 0, c_s = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] bcd(input int h, input int m,
                                      input int s);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10),
            3'(s / 10), 4'(s % 10)};
  endfunction

  function automatic void model_press(input bit pm, input bit pi);
    if (pm) begin
      if (m_mode == 0) begin
        m_h = c_h; m_m = c_m; m_s = c_s; m_mode = 1;
      end else if (m_mode == 3) begin
        m_mode = 0;
      end else begin
        m_mode++;
      end
    end else if (pi && m_mode != 0) begin
      if (m_mode == 1)      m_h = (m_h + 1) % 24;
      else if (m_mode == 2) m_m = (m_m + 1) % 60;
      else                  m_s = (m_s + 1) % 60;
    end
  endfunction

  task automatic set_cur(input int h, input int m, input int s);
    {cur_hour_h, cur_hour_l, cur_minute_h, cur_minute_l,
     cur_second_h, cur_second_l} = bcd(h, m, s);
    c_h = h; c_m = m; c_s = s;
  endtask

  task automatic step();
    @(negedge clk);
    if (prev_load)
      check("stop_after_load", 32'(stop), 32'd0);
    prev_load = load;
    if (load) begin
      load_cnt++;
      check("load_mode", 32'(mode), 32'd0);
      check("load_stop", 32'(stop), 32'd1);
      check("load_set", 32'(set_all), 32'(bcd(m_h, m_m, m_s)));
    end
  endtask

  task automatic do_press(input bit pm, input bit pi);
    int lc;
    bit exp_load;
    lc = load_cnt;
    exp_load = pm && (m_mode == 3);
    model_press(pm, pi);
    btn_mode = pm;
    btn_inc  = pi;
    repeat (HOLD) step();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (HOLD) step();
    check("mode", 32'(mode), 32'(m_mode));
    check("set", 32'(set_all), 32'(bcd(m_h, m_m, m_s)));
    check("stop", 32'(stop), 32'(m_mode != 0));
    check("load_count", 32'(load_cnt - lc), 32'(exp_load));
  endtask

  task automatic wait_mode(input int tgt);
    for (int k = 0; k < 30 && mode != 2'(tgt); k++) step();
    check("wait_mode", 32'(mode), 32'(tgt));
  endtask

  task automatic edit_cycle(input int h, input int m, input int s,
                            input int nh, input int nm, input int ns);
    set_cur(h, m, s);
    do_press(1'b1, 1'b0);
    for (int i = 0; i < nh; i++) do_press(1'b0, 1'b1);
    do_press(1'b1, 1'b0);
    for (int i = 0; i < nm; i++) do_press(1'b0, 1'b1);
    do_press(1'b1, 1'b0);
    for (int i = 0; i < ns; i++) do_press(1'b0, 1'b1);
    do_press(1'b1, 1'b0);
  endtask

  initial begin
    int lat;
    int lc;
    reset    = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    set_cur(0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_stop", 32'(stop), 32'd0);
    check("rst_load", 32'(load), 32'd0);
    check("rst_blink", 32'(blink), 32'd0);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_set", 32'(set_all), 32'd0);
    reset = 1'b1;
    repeat (3) step();

    // held mode button: one pulse, FSM moves 8 edges after rise
    set_cur(12, 34, 56);
    btn_mode = 1'b1;
    lat = -1;
    for (int j = 0; j < 20; j++) begin
      step();
      if (mode == 2'd1 && lat < 0) lat = j;
    end
    check("press_latency", 32'(lat), 32'd8);
    repeat (100) step();
    model_press(1'b1, 1'b0);
    check("held_one_pulse", 32'(mode), 32'd1);
    check("entry_set", 32'(set_all), 32'(bcd(12, 34, 56)));
    check("entry_stop", 32'(stop), 32'd1);
    btn_mode = 1'b0;
    repeat (HOLD) step();

    // bouncing increment must not register
    for (int j = 0; j < 10; j++) begin
      btn_inc = ~btn_inc;
      step();
      step();
    end
    btn_inc = 1'b0;
    repeat (HOLD) step();
    check("bounce_set", 32'(set_all), 32'(bcd(12, 34, 56)));
    check("bounce_mode", 32'(mode), 32'd1);

    repeat (3) do_press(1'b0, 1'b1);
    check("hour15", 32'(set_all), 32'(bcd(15, 34, 56)));
    repeat (3) do_press(1'b1, 1'b0);
    check("after_load_set", 32'(set_all), 32'(bcd(15, 34, 56)));

    // wrap-around and carries
    edit_cycle(23, 59, 59, 1, 1, 1);
    check("wrap_all", 32'(set_all), 32'd0);
    edit_cycle(9, 9, 9, 1, 1, 1);
    check("carry_10", 32'(set_all), 32'(bcd(10, 10, 10)));
    edit_cycle(19, 49, 39, 1, 1, 1);
    for (int it = 0; it < 4; it++)
      edit_cycle($urandom_range(0, 23), $urandom_range(0, 59),
                 $urandom_range(0, 59), $urandom_range(0, 2),
                 $urandom_range(0, 2), $urandom_range(0, 2));

    // blink timing in SET_M and SET_S
    set_cur(1, 2, 3);
    do_press(1'b1, 1'b0);
    btn_mode = 1'b1;
    wait_mode(2);
    for (int k = 0; k < 24; k++) begin
      if (k > 0) step();
      check("blink_m", 32'(blink),
            ((k / BH) % 2) != 0 ? 32'h0c : 32'h0);
    end
    btn_mode = 1'b0;
    model_press(1'b1, 1'b0);
    repeat (HOLD) step();
    btn_mode = 1'b1;
    wait_mode(3);
    for (int k = 0; k < 12; k++) begin
      if (k > 0) step();
      check("blink_s", 32'(blink),
            ((k / BH) % 2) != 0 ? 32'h03 : 32'h0);
    end
    btn_mode = 1'b0;
    model_press(1'b1, 1'b0);
    repeat (HOLD) step();
    do_press(1'b1, 1'b0);
    for (int k = 0; k < 30; k++) begin
      step();
      check("blink_run", 32'(blink), 32'd0);
    end

    // simultaneous presses and increment in RUN
    set_cur(7, 8, 9);
    do_press(1'b1, 1'b0);
    do_press(1'b1, 1'b1);
    check("simul_mode", 32'(mode), 32'd2);
    check("simul_hour", 32'(set_all), 32'(bcd(7, 8, 9)));
    do_press(1'b1, 1'b0);
    do_press(1'b1, 1'b0);
    do_press(1'b0, 1'b1);

    // asynchronous reset mid-edit
    set_cur(15, 40, 56);
    do_press(1'b1, 1'b0);
    do_press(1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_stop", 32'(stop), 32'd0);
    check("mid_rst_load", 32'(load), 32'd0);
    check("mid_rst_blink", 32'(blink), 32'd0);
    check("mid_rst_mode", 32'(mode), 32'd0);
    check("mid_rst_set", 32'(set_all), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    prev_load = 1'b0;
    m_mode = 0; m_h = 0; m_m = 0; m_s = 0;
    lc = load_cnt;
    repeat (30) step();
    check("post_rst_load", 32'(load_cnt - lc), 32'd0);
    check("post_rst_mode", 32'(mode), 32'd0);
    check("post_rst_set", 32'(set_all), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
